// File: rtl/tt_capture_pkg.sv
// -----------------------------------------------------------------------------
// tt_capture_pkg
// Shared definitions for the tt_capture_pipe slice.
//   mode_e          : 2-bit operating mode of the capture pipe
//   mode_shifts_data: true for the modes in which an enabled cycle writes the
//                     stage registers (everything except HOLD)
// -----------------------------------------------------------------------------
package tt_capture_pkg;

  typedef enum logic [1:0] {
    MODE_DELAY    = 2'b00,  // shift d in, count fill up to DEPTH
    MODE_HOLD     = 2'b01,  // freeze stages and fill
    MODE_RECIRC   = 2'b10,  // rotate oldest stage back into stage 0
    MODE_LOAD_ALL = 2'b11   // broadcast d into every stage
  } mode_e;

  function automatic logic mode_shifts_data(input mode_e m);
    return (m != MODE_HOLD);
  endfunction

endpackage

// File: rtl/tt_capture_pipe_if.sv
// -----------------------------------------------------------------------------
// tt_capture_pipe_if
// Bundles the control/data bus of tt_capture_pipe.
//   en        : stage update enable for the current cycle
//   clr       : synchronous clear, wins over en
//   mode      : operating mode (tt_capture_pkg::mode_e)
//   d         : capture data, WIDTH bits
//   tap_sel   : stage index presented on q_tap, TAPW bits
//   q         : oldest stage (DEPTH-1), registered
//   q_tap     : stage selected by tap_sel, 0 when tap_sel >= DEPTH
//   tap_valid : tap_sel < fill
//   full      : fill == DEPTH
//   fill      : number of stages holding genuine samples, FILLW bits
// Modports: master drives the controls and reads the results; slave is the
// capture pipe itself.
// -----------------------------------------------------------------------------
interface tt_capture_pipe_if
  import tt_capture_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
);

  localparam int TAPW  = $clog2(DEPTH);
  localparam int FILLW = $clog2(DEPTH + 1);

  logic             en;
  logic             clr;
  mode_e            mode;
  logic [WIDTH-1:0] d;
  logic [TAPW-1:0]  tap_sel;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_tap;
  logic             tap_valid;
  logic             full;
  logic [FILLW-1:0] fill;

  modport master (
    output en, clr, mode, d, tap_sel,
    input  q, q_tap, tap_valid, full, fill
  );

  modport slave (
    input  en, clr, mode, d, tap_sel,
    output q, q_tap, tap_valid, full, fill
  );

endinterface

// File: rtl/tt_capture_stage.sv
// -----------------------------------------------------------------------------
// tt_capture_stage
// One WIDTH-bit capture register.
//   clk, rst_n : clock and asynchronous active-low reset (clears q)
//   clr        : synchronous clear, priority over load
//   load       : write enable
//   use_load   : 1 selects load_in, 0 selects shift_in as the write source
//   shift_in   : neighbouring-stage source (shift / rotate path)
//   load_in    : broadcast source
//   q          : stored value
// -----------------------------------------------------------------------------
module tt_capture_stage #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             use_load,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [WIDTH-1:0] load_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= use_load ? load_in : shift_in;
    end
  end

endmodule

// File: rtl/tt_capture_pipe.sv
// -----------------------------------------------------------------------------
// tt_capture_pipe
// DEPTH-stage capture pipe with delay, hold, recirculate and broadcast-load
// modes, a fill counter and a random-access tap.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset; zeroes every stage and fill
//   bus   : tt_capture_pipe_if.slave carrying en, clr, mode, d, tap_sel in and
//           q, q_tap, tap_valid, full, fill out
// Stage 0 is the newest sample, stage DEPTH-1 the oldest (driven on q).
// -----------------------------------------------------------------------------
module tt_capture_pipe
  import tt_capture_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  tt_capture_pipe_if.slave bus
);

  localparam int TAPW  = $clog2(DEPTH);
  localparam int FILLW = $clog2(DEPTH + 1);
  localparam logic [FILLW-1:0] FILL_MAX = FILLW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [FILLW-1:0] fill_r;
  logic             stage_load;

  function automatic logic [FILLW-1:0] fill_sat_inc(input logic [FILLW-1:0] f);
    return (f == FILL_MAX) ? FILL_MAX : f + 1'b1;
  endfunction

  // Mode is used combinationally in the same cycle it arrives.
  assign stage_load = bus.en && mode_shifts_data(bus.mode);

  // Stage 0 takes d in DELAY/LOAD_ALL and the oldest stage in RECIRC; the
  // other stages take their predecessor except in LOAD_ALL, where d is
  // broadcast.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             use_load;
    logic [WIDTH-1:0] shift_src;

    if (i == 0) begin : g_head
      assign use_load  = (bus.mode != MODE_RECIRC);
      assign shift_src = stage_q[DEPTH-1];
    end else begin : g_body
      assign use_load  = (bus.mode == MODE_LOAD_ALL);
      assign shift_src = stage_q[i-1];
    end

    tt_capture_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.clr),
      .load     (stage_load),
      .use_load (use_load),
      .shift_in (shift_src),
      .load_in  (bus.d),
      .q        (stage_q[i])
    );
  end

  // Fill counter: DELAY counts genuine samples in, LOAD_ALL marks every stage
  // genuine, RECIRC only reorders so the count is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= '0;
    end else if (bus.clr) begin
      fill_r <= '0;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_DELAY:    fill_r <= fill_sat_inc(fill_r);
        MODE_LOAD_ALL: fill_r <= FILL_MAX;
        default:       fill_r <= fill_r;
      endcase
    end
  end

  // Tap mux: compare against each legal index so that tap_sel values beyond
  // DEPTH-1 (non-power-of-two DEPTH) fall through to zero.
  always_comb begin
    bus.q_tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.tap_sel == TAPW'(i)) begin
        bus.q_tap = stage_q[i];
      end
    end
  end

  // fill never exceeds DEPTH, so an out-of-range tap_sel is never valid.
  assign bus.tap_valid = (FILLW'(bus.tap_sel) < fill_r);
  assign bus.full      = (fill_r == FILL_MAX);
  assign bus.fill      = fill_r;
  assign bus.q         = stage_q[DEPTH-1];

endmodule

// File: tb/tb_tt_capture_pipe.sv
module tb_tt_capture_pipe;
  import tt_capture_pkg::*;

  localparam int W = 6;
  localparam int DEP [2] = '{4, 3};

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  mode_e      mode;
  logic [5:0] d;
  logic [1:0] tap_sel;
  logic       chk_on;

  int total;
  int bad;

  // Behavioural model: plain array of stage contents per DUT, newest first.
  int unsigned mdl [2][16];
  int          mfill [2];

  tt_capture_pipe_if #(.WIDTH(W), .DEPTH(4)) b4 ();
  tt_capture_pipe_if #(.WIDTH(W), .DEPTH(3)) b3 ();

  assign b4.en = en;  assign b4.clr = clr;  assign b4.mode = mode;
  assign b4.d  = d;   assign b4.tap_sel = tap_sel;
  assign b3.en = en;  assign b3.clr = clr;  assign b3.mode = mode;
  assign b3.d  = d;   assign b3.tap_sel = tap_sel;

  tt_capture_pipe #(.WIDTH(W), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  tt_capture_pipe #(.WIDTH(W), .DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mdl[k][i] = 0;
      mfill[k] = 0;
    end
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_step();
    int unsigned oldest;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        for (int i = 0; i < 16; i++) mdl[k][i] = 0;
        mfill[k] = 0;
      end else if (en) begin
        if (mode == MODE_DELAY) begin
          for (int i = DEP[k] - 1; i > 0; i--) mdl[k][i] = mdl[k][i-1];
          mdl[k][0] = d;
          mfill[k] = (mfill[k] + 1 > DEP[k]) ? DEP[k] : mfill[k] + 1;
        end else if (mode == MODE_RECIRC) begin
          oldest = mdl[k][DEP[k]-1];
          for (int i = DEP[k] - 1; i > 0; i--) mdl[k][i] = mdl[k][i-1];
          mdl[k][0] = oldest;
        end else if (mode == MODE_LOAD_ALL) begin
          for (int i = 0; i < DEP[k]; i++) mdl[k][i] = d;
          mfill[k] = DEP[k];
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_tap(input int k);
    return (int'(tap_sel) < DEP[k]) ? mdl[k][tap_sel] : 0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("q4",     32'(b4.q),         mdl[0][3]);
      chk("tap4",   32'(b4.q_tap),     exp_tap(0));
      chk("vld4",   32'(b4.tap_valid), 32'(int'(tap_sel) < mfill[0]));
      chk("full4",  32'(b4.full),      32'(mfill[0] == 4));
      chk("fill4",  32'(b4.fill),      mfill[0]);
      chk("q3",     32'(b3.q),         mdl[1][2]);
      chk("tap3",   32'(b3.q_tap),     exp_tap(1));
      chk("vld3",   32'(b3.tap_valid), 32'(int'(tap_sel) < mfill[1]));
      chk("full3",  32'(b3.full),      32'(mfill[1] == 3));
      chk("fill3",  32'(b3.fill),      mfill[1]);
    end
  end

  task automatic step(input logic e, input logic c, input mode_e m, input logic [5:0] dv);
    en = e; clr = c; mode = m; d = dv;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_q",    32'(b4.q),    0);
    chk("arst_fill", 32'(b4.fill), 0);
    chk("arst_full", 32'(b4.full), 0);
    chk("arst_vld",  32'(b4.tap_valid), 0);
    #1;
    rst_n = 1'b1;
  endtask

  logic [5:0] rc_exp [4];
  logic [2:0] fill_exp [5];

  initial begin
    total = 0; bad = 0; chk_on = 1'b0;
    en = 1'b0; clr = 1'b0; mode = MODE_DELAY; d = '0; tap_sel = '0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    chk("rst_q",    32'(b4.q), 0);
    chk("rst_fill", 32'(b4.fill), 0);
    chk("rst_full", 32'(b4.full), 0);
    #10 rst_n = 1'b1;

    // DELAY latency and fill count.
    fill_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, MODE_DELAY, 6'(i + 1));
      chk("dly_fill", 32'(b4.fill), 32'(fill_exp[i]));
      chk("dly_full", 32'(b4.full), 32'(i >= 3));
      if (i == 3) chk("dly_q4", 32'(b4.q), 1);
      if (i == 4) chk("dly_q5", 32'(b4.q), 2);
    end

    // RECIRC rotation.
    step(1'b1, 1'b1, MODE_DELAY, 6'h00);
    step(1'b1, 1'b0, MODE_DELAY, 6'h0D);
    step(1'b1, 1'b0, MODE_DELAY, 6'h0C);
    step(1'b1, 1'b0, MODE_DELAY, 6'h0B);
    step(1'b1, 1'b0, MODE_DELAY, 6'h0A);
    tap_sel = 2'd2;
    rc_exp = '{6'h0C, 6'h0B, 6'h0A, 6'h0D};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, MODE_RECIRC, 6'h3F);
      chk("rc_q",    32'(b4.q), 32'(rc_exp[i]));
      chk("rc_fill", 32'(b4.fill), 4);
    end

    // HOLD mid-fill.
    step(1'b1, 1'b1, MODE_DELAY, 6'h00);
    step(1'b1, 1'b0, MODE_DELAY, 6'h01);
    step(1'b1, 1'b0, MODE_DELAY, 6'h02);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, MODE_HOLD, 6'(6'h11 + 6'(i)));
    tap_sel = 2'd0; #1;
    chk("hold_tap0", 32'(b4.q_tap), 2);
    tap_sel = 2'd1; #1;
    chk("hold_tap1", 32'(b4.q_tap), 1);
    chk("hold_vld1", 32'(b4.tap_valid), 1);
    chk("hold_q",    32'(b4.q), 0);
    chk("hold_fill", 32'(b4.fill), 2);

    // LOAD_ALL from reset, then clr beats en.
    async_reset();
    step(1'b1, 1'b0, MODE_LOAD_ALL, 6'h15);
    for (int i = 0; i < 4; i++) begin
      tap_sel = 2'(i); #1;
      chk("ld_tap", 32'(b4.q_tap), 32'h15);
    end
    chk("ld_fill", 32'(b4.fill), 4);
    chk("ld_full", 32'(b4.full), 1);
    step(1'b1, 1'b1, MODE_LOAD_ALL, 6'h2E);
    chk("clr_q",    32'(b4.q), 0);
    chk("clr_fill", 32'(b4.fill), 0);

    // DEPTH=3: out-of-range tap and fill-gated valid.
    step(1'b1, 1'b0, MODE_LOAD_ALL, 6'h2A);
    tap_sel = 2'd3; #1;
    chk("d3_tap3", 32'(b3.q_tap), 0);
    chk("d3_vld3", 32'(b3.tap_valid), 0);
    step(1'b1, 1'b1, MODE_DELAY, 6'h00);
    step(1'b1, 1'b0, MODE_DELAY, 6'h07);
    tap_sel = 2'd1; #1;
    chk("d3_vld_f1", 32'(b3.tap_valid), 0);
    step(1'b1, 1'b0, MODE_DELAY, 6'h08);
    chk("d3_vld_f2", 32'(b3.tap_valid), 1);
    chk("d3_tap_f2", 32'(b3.q_tap), 7);

    // en low holds in every mode; width boundary value.
    step(1'b1, 1'b0, MODE_DELAY, 6'h3F);
    step(1'b0, 1'b0, MODE_DELAY, 6'h01);
    step(1'b0, 1'b0, MODE_HOLD, 6'h02);
    step(1'b0, 1'b0, MODE_RECIRC, 6'h03);
    step(1'b0, 1'b0, MODE_LOAD_ALL, 6'h04);
    tap_sel = 2'd0; #1;
    chk("enlo_tap0", 32'(b4.q_tap), 32'h3F);
    chk("enlo_fill", 32'(b4.fill), 3);

    // Mode switches every cycle, then reset mid-RECIRC.
    step(1'b1, 1'b0, MODE_RECIRC, 6'h05);
    step(1'b1, 1'b0, MODE_DELAY, 6'h06);
    step(1'b1, 1'b0, MODE_RECIRC, 6'h07);
    tap_sel = 2'd3;
    async_reset();

    // Full in DELAY, then async reset between edges.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, MODE_DELAY, 6'(6'h20 + 6'(i)));
    chk("pre_full", 32'(b4.full), 1);
    chk("pre_q",    32'(b4.q), 32'h21);
    async_reset();
    step(1'b1, 1'b0, MODE_DELAY, 6'h33);
    chk("post_fill", 32'(b4.fill), 1);

    step(1'b0, 1'b0, MODE_HOLD, 6'h00);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_capture_pipe.md
TT_CAPTURE_PIPE -- requirements
Module: tt_capture_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, meaning data bits per stage; legal range 1..32.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of capture stages; legal range 2..16.
REQ-003 The block SHALL have derived constant TAPW = clog2(DEPTH) and FILLW = clog2(DEPTH+1).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port en, input, 1, the stage update enable for the current cycle.
REQ-007 The block SHALL have port clr, input, 1, the synchronous clear; it has priority over en.
REQ-008 The block SHALL have port mode, input, 2, the operating mode (see Function).
REQ-009 The block SHALL have port d, input, WIDTH, the capture data.
REQ-010 The block SHALL have port tap_sel, input, TAPW, the stage index for q_tap.
REQ-011 The block SHALL have port q, output, WIDTH, the oldest stage (stage DEPTH-1), driven directly from a register.
REQ-012 The block SHALL have port q_tap, output, WIDTH, the stage selected by tap_sel (combinational mux of registers).
REQ-013 The block SHALL have port tap_valid, output, 1, high when tap_sel < fill.
REQ-014 The block SHALL have port full, output, 1, high when fill == DEPTH.
REQ-015 The block SHALL have port fill, output, FILLW, the count of stages holding genuine samples.

Function
REQ-016 mode 00 DELAY: on en, stage0 <= d, stage i <= stage i-1, and fill increments saturating at DEPTH.
REQ-017 In DELAY with en high every cycle, d sampled at edge k SHALL appear on q after edge k+DEPTH-1 (DEPTH en-edges of latency).
REQ-018 mode 01 HOLD: stages and fill SHALL remain unchanged regardless of en.
REQ-019 mode 10 RECIRC: on en, stage0 <= stage DEPTH-1 and stage i <= stage i-1 (rotate); fill unchanged.
REQ-020 mode 11 LOAD_ALL: on en, every stage <= d, and fill <= DEPTH.
REQ-021 With en low and clr low, all state SHALL hold in every mode.
REQ-022 clr high SHALL zero all stages and fill at the next edge, regardless of en and mode.
REQ-023 When tap_sel >= DEPTH (non-power-of-two DEPTH), q_tap SHALL be 0 and tap_valid SHALL be 0.
REQ-024 A DELAY shift with full high SHALL discard the old stage DEPTH-1 value silently; full stays high.
REQ-025 A mode change SHALL take effect in the same cycle it is presented; no pipeline of mode.

Reset
REQ-026 rst_n low SHALL asynchronously force all stages to 0, fill to 0, and therefore q=0, q_tap=0, tap_valid=0, full=0.
REQ-027 Reset deassertion SHALL be the only reset path; the first update SHALL occur on the first rising clk edge with rst_n high.
REQ-028 Reset asserted mid-operation in any mode SHALL abort the operation with no partial state retained.

Structure
REQ-029 The mode encodings (DELAY, HOLD, RECIRC, LOAD_ALL) SHALL live in shared package tt_capture_pkg as a 2-bit enumerated type.
REQ-030 One sub-module tt_capture_stage SHALL be used per stage: WIDTH-bit register with async active-low reset, clear, and load-enable with selectable source.
REQ-031 The fill counter and tap mux SHALL reside in tt_capture_pipe.

Verification
REQ-032 Reset, then DELAY with en=1 and d=1,2,3,4,5 on successive edges (DEPTH=4) -> q=1 after 4th edge, q=2 after 5th; full rises after 4th edge; fill=1,2,3,4,4.
REQ-033 Fill to 0x0A,0x0B,0x0C,0x0D, then RECIRC en=1 for 4 edges -> q sequence 0x0C,0x0B,0x0A,0x0D; fill stays 4.
REQ-034 Mid-fill (fill=2), HOLD with en=1 and changing d for 5 edges -> stages, q, and fill unchanged.
REQ-035 LOAD_ALL en=1 d=0x15 from reset -> every tap_sel reads 0x15, fill=4, full=1; then clr=1 with en=1 -> all zero, fill=0.
REQ-036 DEPTH=3 build, tap_sel=3 -> q_tap=0, tap_valid=0; tap_sel=1 with fill=1 -> tap_valid=0; with fill=2 -> tap_valid=1.
REQ-037 Assert rst_n low between clock edges while full in DELAY -> q, fill, and full go to 0 immediately, with no clock edge.
